pipeline_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the IF/ID pipeline register and PC of the 4-stage MIPS core.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 9 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: controller state encodings and the hard-wired zero register specifier.
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_WAIT_FETCH = 2'd2
  } state_t;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and the instruction in ID.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rt,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  load_use
);
  // A load into $zero never produces a value, so it cannot create a dependency.
  assign load_use = mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO)) &&
                    ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: IF/ID + PC hazard sequencer; optional counters under `define STALL_COUNTER_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Imem_Ready,
  input  logic                  Branch_Taken,
  input  logic                  Jump,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  IF_ID_Uses_Rt,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Bubble,
  output logic [CNT_W-1:0]      Stall_Count,
  output logic [CNT_W-1:0]      Flush_Count
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  state_t        state;
  logic [FW-1:0] fcnt;
  logic          load_use, redirect;
  logic          pc_w, ifid_w, flush, bubble;
  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .rs       (IF_ID_Rs),
    .rt       (IF_ID_Rt),
    .uses_rt  (IF_ID_Uses_Rt),
    .mem_read (ID_EX_MemRead),
    .ex_rt    (ID_EX_Rt),
    .load_use (load_use)
  );
  assign redirect = Branch_Taken | Jump;
  always_comb begin
    pc_w   = 1'b1;
    ifid_w = 1'b1;
    flush  = 1'b0;
    bubble = 1'b0;
    if (redirect) flush = 1'b1;
    else if (state == ST_FLUSH) begin
      flush = 1'b1;
      pc_w  = Imem_Ready;
    end else if (state == ST_WAIT_FETCH) begin
      flush = !Imem_Ready;
      pc_w  = Imem_Ready;
    end else if (load_use) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      bubble = 1'b1;
    end else if (!Imem_Ready) begin
      pc_w  = 1'b0;
      flush = 1'b1;
    end
  end
  assign PC_Write     = !Reset && pc_w;
  assign IF_ID_Write  = !Reset && ifid_w;
  assign IF_ID_Flush  = Reset || flush;
  assign ID_EX_Bubble = Reset || bubble;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else if (redirect) begin
      state <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      fcnt  <= FW'(FLUSH_CYCLES - 1);
    end else begin
      case (state)
        ST_RUN:        if (!load_use && !Imem_Ready) state <= ST_WAIT_FETCH;
        ST_FLUSH: if (Imem_Ready) begin
          fcnt <= fcnt - 1'b1;
          if (fcnt == FW'(1)) state <= ST_RUN;
        end
        ST_WAIT_FETCH: if (Imem_Ready) state <= ST_RUN;
        default:       state <= ST_RUN;
      endcase
    end
  end
`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  // Bubble outside reset is only ever raised by a load-use stall.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
  assign Stall_Count = stall_cnt;
  assign Flush_Count = flush_cnt;
`else
  assign Stall_Count = '0;
  assign Flush_Count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random stimulus against a behavioural model of the controller.
module tb_pipeline_hazard_ctrl;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst, ready, br, jp, uses_rt, mem_read;
  logic [4:0] rs, rt, ex_rt;
  logic pc_write, ifid_write, ifid_flush, bubble;
  logic [CW-1:0] stall_count, flush_count;
  int total = 0;
  int bad = 0;
  int flush_left = 0;
  bit waiting = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .Clk(clk), .Reset(rst), .Imem_Ready(ready), .Branch_Taken(br), .Jump(jp),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_Uses_Rt(uses_rt), .ID_EX_MemRead(mem_read),
    .ID_EX_Rt(ex_rt), .PC_Write(pc_write), .IF_ID_Write(ifid_write), .IF_ID_Flush(ifid_flush),
    .ID_EX_Bubble(bubble), .Stall_Count(stall_count), .Flush_Count(flush_count)
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // One clock cycle: drive inputs after negedge, compare, then advance the model.
  task automatic step(input bit r, input bit b, input bit j, input bit rdy, input bit mr,
                      input bit ur, input int s, input int t, input int e);
    bit lu, e_pc, e_wr, e_fl, e_bub, wr_known;
    @(negedge clk);
    rst = r; br = b; jp = j; ready = rdy; mem_read = mr; uses_rt = ur;
    rs = 5'(s); rt = 5'(t); ex_rt = 5'(e);
    #1;
    lu = mr && e != 0 && (e == s || (ur && e == t));
    wr_known = 1'b1;
    e_pc = 1'b1; e_wr = 1'b1; e_fl = 1'b0; e_bub = 1'b0;
    if (r) begin
      flush_left = 0; waiting = 1'b0; m_stall = 0; m_flush = 0;
      e_pc = 1'b0; e_wr = 1'b0; e_fl = 1'b1; e_bub = 1'b1;
    end else if (b || j) begin
      e_fl = 1'b1; wr_known = 1'b0;
    end else if (flush_left > 0) begin
      e_fl = 1'b1; e_pc = rdy; wr_known = 1'b0;
    end else if (waiting) begin
      e_pc = rdy; e_fl = !rdy; wr_known = rdy;
    end else if (lu) begin
      e_pc = 1'b0; e_wr = 1'b0; e_bub = 1'b1;
    end else if (!rdy) begin
      e_pc = 1'b0; e_fl = 1'b1; wr_known = 1'b0;
    end
    check("pc_write", int'(pc_write), int'(e_pc));
    check("ifid_flush", int'(ifid_flush), int'(e_fl));
    check("bubble", int'(bubble), int'(e_bub));
    if (wr_known) check("ifid_write", int'(ifid_write), int'(e_wr));
`ifdef STALL_COUNTER_EN
    check("stall_count", int'(stall_count), m_stall);
    check("flush_count", int'(flush_count), m_flush);
`else
    check("stall_count", int'(stall_count), 0);
    check("flush_count", int'(flush_count), 0);
`endif
    if (!r) begin
      if (e_bub) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (e_fl) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (b || j) begin
        flush_left = FC - 1; waiting = 1'b0;
      end else if (flush_left > 0) begin
        if (rdy) flush_left--;
      end else if (waiting) begin
        if (rdy) waiting = 1'b0;
      end else if (!lu && !rdy) waiting = 1'b1;
    end
  endtask
  initial begin
    rst = 1'b1; ready = 1'b1; br = 1'b0; jp = 1'b0; uses_rt = 1'b0; mem_read = 1'b0;
    rs = '0; rt = '0; ex_rt = '0;
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 2, 3);
    step(0, 0, 0, 1, 1, 0, 8, 0, 8);
    step(0, 0, 0, 1, 0, 0, 8, 0, 8);
    step(0, 0, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 3, 9, 9);
    step(0, 0, 0, 1, 1, 1, 3, 9, 9);
    step(0, 1, 0, 1, 1, 1, 8, 8, 8);
    step(0, 0, 0, 1, 1, 1, 8, 8, 8);
    step(0, 0, 0, 1, 1, 1, 8, 8, 8);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0, 5, 0, 6);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 0, 5, 0, 5);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
           $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
           int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
